// File: rtl/ariane_pkg.sv
// Minimal ariane_pkg providing the transaction-id width shared with the scoreboard.
package ariane_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;
endpackage

// File: rtl/mac8_acc_commit.sv
// Speculative MAC8 accumulator buffer: FU results queue in order and retire into the
// architectural accumulator on commit. Optional committed-overflow tracking: MAC8_OVF_STICKY_EN.
module mac8_acc_commit
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       res_valid_i,
    output logic                       res_ready_o,
    input  logic signed [31:0]         res_value_i,
    input  logic [TRANS_ID_BITS-1:0]   res_trans_id_i,
    input  logic                       res_ovf_i,
    input  logic                       commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0]   commit_trans_id_i,
    output logic                       commit_ack_o,
    output logic                       commit_err_o,
    input  logic                       flush_i,
    output logic signed [31:0]         spec_acc_o,
    output logic signed [31:0]         arch_acc_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ovf_sticky_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic signed [31:0]        r_val [DEPTH];
    logic [TRANS_ID_BITS-1:0]  r_id  [DEPTH];
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic signed [31:0]        r_arch;

    logic                      w_not_empty;
    logic                      w_hit;
    logic                      w_push;
    logic [PTR_W-1:0]          w_tail_m1;

    assign w_not_empty  = (r_count != '0);
    assign res_ready_o  = (r_count < CNT_W'(DEPTH));
    assign w_hit        = commit_valid_i && w_not_empty && (r_id[r_head] == commit_trans_id_i);
    // A push in a flush cycle would be speculative work the flush is discarding.
    assign w_push       = res_valid_i && res_ready_o && !flush_i;

    assign commit_ack_o = w_hit;
    assign commit_err_o = commit_valid_i && !w_hit;

    assign w_tail_m1    = r_tail - PTR_W'(1);
    assign spec_acc_o   = w_not_empty ? r_val[w_tail_m1] : r_arch;
    assign arch_acc_o   = r_arch;
    assign count_o      = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_arch  <= '0;
        end else begin
            if (w_hit) begin
                r_arch <= r_val[r_head];
            end
            // Commit lands in r_arch above before the flush empties the queue.
            if (flush_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_hit) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                case ({w_push, w_hit})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_val[r_tail] <= res_value_i;
            r_id[r_tail]  <= res_trans_id_i;
        end
    end

`ifdef MAC8_OVF_STICKY_EN
    logic r_ovf [DEPTH];
    logic r_sticky;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ovf[r_tail] <= res_ovf_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sticky <= 1'b0;
        end else if (w_hit && r_ovf[r_head]) begin
            r_sticky <= 1'b1;
        end
    end

    assign ovf_sticky_o = r_sticky;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = res_ovf_i;
    assign ovf_sticky_o = 1'b0;
`endif

endmodule

// File: doc/mac8_acc_commit.md
MAC8_ACC_COMMIT -- requirements
Module: mac8_acc_commit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of speculative accumulator entries held (power of two, >= 2).
REQ-002 SHALL take TRANS_ID_BITS from ariane_pkg; no local override.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports:
  clk_i  input  1  clock, all state on rising edge
  rst_ni  input  1  synchronous active-low reset
  res_valid_i  input  1  MAC8 FU result valid
  res_ready_o  output  1  buffer can accept a result
  res_value_i  input  32  FU accumulator result (signed)
  res_trans_id_i  input  TRANS_ID_BITS  FU result transaction id
  res_ovf_i  input  1  FU flags signed overflow for this result
  commit_valid_i  input  1  commit stage retires a MAC8 instruction
  commit_trans_id_i  input  TRANS_ID_BITS  id being retired
  commit_ack_o  output  1  head entry retired this cycle
  commit_err_o  output  1  commit attempted on empty buffer or id mismatch
  flush_i  input  1  discard all speculative entries
  spec_acc_o  output  32  speculative accumulator for the FU's next MAC8_ACC
  arch_acc_o  output  32  architectural (committed) accumulator
  count_o  output  $clog2(DEPTH)+1  occupied entries
  ovf_sticky_o  output  1  sticky committed-overflow flag

Function
REQ-005 SHALL store entries {value, trans_id, ovf} in a circular FIFO with head/tail pointers wrapping at DEPTH.
REQ-006 SHALL drive res_ready_o = (count < DEPTH); push occurs on res_valid_i && res_ready_o; no same-cycle pass-through when full.
REQ-007 SHALL assert commit_ack_o combinationally when commit_valid_i && count>0 && head.trans_id == commit_trans_id_i; on that edge arch_acc <= head.value and head advances.
REQ-008 SHALL assert commit_err_o combinationally when commit_valid_i && (count==0 || id mismatch); no state change results.
REQ-009 SHALL leave count unchanged on simultaneous push and pop; full-and-pop with res_valid_i does not push (ready was low).
REQ-010 SHALL drive spec_acc_o = tail-1 entry value when count>0, else arch_acc_o; purely from registers; a pushed value appears on spec_acc_o one cycle after push.
REQ-011 SHALL on flush_i: apply any same-cycle valid commit first, then empty all remaining entries (count=0 next cycle); a push in the flush cycle is dropped; arch_acc_o is never altered by flush.
REQ-012 SHALL treat values as two's-complement 32-bit; arch_acc_o copies committed value exactly, no arithmetic.
REQ-013 SHALL keep res_ready_o high the cycle after flush.
REQ-014 SHALL be single-cycle throughput: one push and one commit per cycle sustained.

Reset
REQ-015 SHALL on rst_ni low at clock edge: pointers=0, count_o=0, arch_acc_o=0, ovf_sticky_o=0; pending entries discarded regardless of in-flight commit or push.
REQ-016 SHALL after reset show res_ready_o=1, commit_ack_o=0, commit_err_o=0 (with inputs idle), spec_acc_o=0.

Configuration
REQ-017 SHALL with MAC8_OVF_STICKY_EN defined: set ovf_sticky_o on the edge a commit retires an entry with ovf=1; clear only by reset; flushed entries never set it.
REQ-018 SHALL without MAC8_OVF_STICKY_EN: ovf_sticky_o tied 0, no ovf storage in entries, res_ovf_i ignored.

Verification
REQ-019 Reset, push 0x00000010 id 3 -> next cycle spec_acc_o=0x10, count_o=1, arch_acc_o=0.
REQ-020 Push ids 1..4 (values 1..4), DEPTH=4 -> res_ready_o=0; commit id 1 -> ack=1, arch_acc_o=1, count_o=3, ready=1.
REQ-021 count_o=2 (ids 5,6), commit id 6 -> commit_err_o=1, ack=0, count_o stays 2, arch_acc_o unchanged.
REQ-022 count_o=3, same cycle commit head id 7 (value 0xFFFFFFF0) + flush + push -> arch_acc_o=0xFFFFFFF0, count_o=0, spec_acc_o=0xFFFFFFF0.
REQ-023 With MAC8_OVF_STICKY_EN: push ovf=1 id 2, flush -> ovf_sticky_o=0; push ovf=1 id 2, commit id 2 -> ovf_sticky_o=1 until reset.
REQ-024 Fill 3 entries, rst_ni low one cycle mid-commit -> count_o=0, arch_acc_o=0, no ack after reset; wrap test: 10 push/pop pairs, values in order.
